// File: rtl/writeback_unit.sv
// Write-back stage: one stage register (S) plus one skid buffer (B) feeding the
// regfile write port, with same-cycle bypass data for both read ports.
module writeback_unit #(
    parameter int DW = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rd,
    input  logic          in_regwrite,
    input  logic          in_memtoreg,
    input  logic          in_link,
    input  logic [DW-1:0] in_alu_result,
    input  logic [DW-1:0] in_mem_data,
    input  logic [DW-1:0] in_pc_plus4,
    input  logic          wr_grant,
    output logic [DW-1:0] WriteData,
    output logic [4:0]    WriteRegister,
    output logic          RegWrite,
    input  logic [4:0]    ReadRegister1,
    input  logic [4:0]    ReadRegister2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2,
    output logic [CW-1:0] commit_count
);

    logic          s_valid_r, s_we_r, b_valid_r, b_we_r;
    logic [4:0]    s_rd_r, b_rd_r;
    logic [DW-1:0] s_data_r, b_data_r;
    logic [CW-1:0] commit_count_r;

    logic [4:0]    cap_rd_s;
    logic [DW-1:0] cap_data_s;
    logic          cap_we_s;
    logic          accept_s, retire_s, s_free_s;
    logic [DW:0]   fwd1_s, fwd2_s;

    // Bypass lookup: the skid buffer holds the younger entry, so it takes priority.
    function automatic logic [DW:0] fwd_lookup(
        input logic [4:0]    rr,
        input logic          bv, input logic bwe, input logic [4:0] brd, input logic [DW-1:0] bdata,
        input logic          sv, input logic swe, input logic [4:0] srd, input logic [DW-1:0] sdata
    );
        logic [DW:0] res;
        if (rr == 5'd31) begin
            res = {1'b0, {DW{1'b0}}};
        end else if (bv && bwe && (brd == rr)) begin
            res = {1'b1, bdata};
        end else if (sv && swe && (srd == rr)) begin
            res = {1'b1, sdata};
        end else begin
            res = {1'b0, {DW{1'b0}}};
        end
        return res;
    endfunction

    // Map an incoming MEM result onto an entry; link overrides rd and the data select.
    always_comb begin
        cap_rd_s   = in_rd;
        cap_data_s = in_alu_result;
        if (in_link) begin
            cap_rd_s   = 5'd30;
            cap_data_s = in_pc_plus4;
        end else if (in_memtoreg) begin
            cap_data_s = in_mem_data;
        end else begin
            cap_data_s = in_alu_result;
        end
        cap_we_s = (in_link | in_regwrite) & (cap_rd_s != 5'd31);
    end

    assign in_ready = ~b_valid_r;
    assign accept_s = in_valid & ~b_valid_r;
    assign retire_s = s_valid_r & wr_grant;
    assign s_free_s = ~s_valid_r | retire_s;
    assign commit_count = commit_count_r;

    // Write port driven straight from S; reset suppresses the write on its edge.
    always_comb begin
        RegWrite = s_valid_r & s_we_r & wr_grant & ~reset;
        if (s_valid_r) begin
            WriteRegister = s_rd_r;
            WriteData     = s_data_r;
        end else begin
            WriteRegister = 5'd31;
            WriteData     = {DW{1'b0}};
        end
    end

    // Forwarding for both read ports.
    always_comb begin
        fwd1_s    = fwd_lookup(ReadRegister1, b_valid_r, b_we_r, b_rd_r, b_data_r,
                               s_valid_r, s_we_r, s_rd_r, s_data_r);
        fwd2_s    = fwd_lookup(ReadRegister2, b_valid_r, b_we_r, b_rd_r, b_data_r,
                               s_valid_r, s_we_r, s_rd_r, s_data_r);
        fwd_hit1  = fwd1_s[DW];
        fwd_data1 = fwd1_s[DW-1:0];
        fwd_hit2  = fwd2_s[DW];
        fwd_data2 = fwd2_s[DW-1:0];
    end

    // Stage/skid state: B drains into S first, preserving acceptance order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid_r <= 1'b0;
            s_we_r    <= 1'b0;
            s_rd_r    <= 5'd31;
            s_data_r  <= {DW{1'b0}};
            b_valid_r <= 1'b0;
            b_we_r    <= 1'b0;
            b_rd_r    <= 5'd31;
            b_data_r  <= {DW{1'b0}};
        end else if (s_free_s) begin
            if (b_valid_r) begin
                s_valid_r <= 1'b1;
                s_we_r    <= b_we_r;
                s_rd_r    <= b_rd_r;
                s_data_r  <= b_data_r;
                b_valid_r <= 1'b0;
            end else if (accept_s) begin
                s_valid_r <= 1'b1;
                s_we_r    <= cap_we_s;
                s_rd_r    <= cap_rd_s;
                s_data_r  <= cap_data_s;
            end else begin
                s_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            b_valid_r <= 1'b1;
            b_we_r    <= cap_we_s;
            b_rd_r    <= cap_rd_s;
            b_data_r  <= cap_data_s;
        end else begin
            b_valid_r <= b_valid_r;
        end
    end

    // Count of performed writes, wrapping naturally at 2^CW.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_count_r <= {CW{1'b0}};
        end else if (RegWrite) begin
            commit_count_r <= commit_count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            commit_count_r <= commit_count_r;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized
// run compared against an in-order queue model of pending writes.
module tb_writeback_unit;
    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, in_regwrite, in_memtoreg, in_link, wr_grant;
    logic [4:0]    in_rd, WriteRegister, ReadRegister1, ReadRegister2;
    logic [DW-1:0] in_alu_result, in_mem_data, in_pc_plus4, WriteData, fwd_data1, fwd_data2;
    logic          RegWrite, fwd_hit1, fwd_hit2;
    logic [CW-1:0] commit_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]    rd;
        logic          we;
        logic [DW-1:0] data;
    } entry_t;

    entry_t q[$];
    int     mcount;

    writeback_unit #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_link(in_link),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
        .wr_grant(wr_grant), .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    // Reference expectations derived from the queue of pending results (oldest first).
    function automatic logic exp_regwrite();
        return (q.size() > 0) && q[0].we && wr_grant;
    endfunction
    function automatic logic [4:0] exp_wreg();
        return (q.size() > 0) ? q[0].rd : 5'd31;
    endfunction
    function automatic logic [DW-1:0] exp_wdata();
        return (q.size() > 0) ? q[0].data : {DW{1'b0}};
    endfunction
    function automatic logic [DW:0] exp_fwd(input logic [4:0] rr);
        for (int i = q.size() - 1; i >= 0; i--)
            if (rr != 5'd31 && q[i].we && q[i].rd == rr) return {1'b1, q[i].data};
        return {1'b0, {DW{1'b0}}};
    endfunction

    task automatic offer(input logic v, input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic lnk, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                         input logic [DW-1:0] pc);
        in_valid = v; in_rd = rd; in_regwrite = rw; in_memtoreg = m2r; in_link = lnk;
        in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc;
        #1;
    endtask

    // One clock edge; the model advances using the inputs held across that edge.
    task automatic tick();
        entry_t e;
        logic acc, ret;
        acc = in_valid && (q.size() < 2);
        ret = (q.size() > 0) && wr_grant;
        e.rd = in_link ? 5'd30 : in_rd;
        e.data = in_link ? in_pc_plus4 : (in_memtoreg ? in_mem_data : in_alu_result);
        e.we = (in_link || in_regwrite) && (e.rd != 5'd31);
        if (reset) begin
            q.delete();
            mcount = 0;
        end else begin
            if (ret) begin
                if (q[0].we) mcount = (mcount + 1) % (1 << CW);
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_grant = 1'b0;
        offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd30; #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
        checks++; if (WriteRegister !== 5'd31) begin errors++; $display("FAIL reset_wreg got=%0d exp=31", WriteRegister); end
        checks++; if (WriteData !== 64'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if ({fwd_hit1, fwd_hit2} !== 2'b00) begin errors++; $display("FAIL reset_fwdhit got=%b exp=00", {fwd_hit1, fwd_hit2}); end
        checks++; if ((fwd_data1 | fwd_data2) !== 64'h0) begin errors++; $display("FAIL reset_fwddata got=%h/%h exp=0", fwd_data1, fwd_data2); end
        checks++; if (commit_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", commit_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_grant = 1'b1;
        offer(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 64'h11, 64'h99, 64'h0);
        tick();
        offer(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 64'h77, 64'h22, 64'h0);
        checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd5, 64'h11}) begin errors++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/5/11", RegWrite, WriteRegister, WriteData); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
        tick();
        offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd6, 64'h22}) begin errors++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/6/22", RegWrite, WriteRegister, WriteData); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got=%b exp=1", in_ready); end
        tick();
        checks++; if (commit_count !== 4'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", commit_count); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", RegWrite); end
    endtask

    task automatic test_xzr_link();
        do_reset();
        wr_grant = 1'b1;
        offer(1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 64'h55, 64'h0, 64'h0);
        tick();
        offer(1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 64'h33, 64'h44, 64'h1004);
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL xzr_nowrite got=%b exp=0", RegWrite); end
        tick();
        offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd30, 64'h1004}) begin errors++; $display("FAIL link_write got=%b/%0d/%h exp=1/30/1004", RegWrite, WriteRegister, WriteData); end
        checks++; if (commit_count !== 4'd0) begin errors++; $display("FAIL xzr_count got=%0d exp=0", commit_count); end
        tick();
        checks++; if (commit_count !== 4'd1) begin errors++; $display("FAIL link_count got=%0d exp=1", commit_count); end
    endtask

    task automatic test_stall_skid();
        do_reset();
        wr_grant = 1'b0;
        offer(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 64'hA, 64'h0, 64'h0);
        tick();
        offer(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 64'hB, 64'h0, 64'h0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_one got=%b exp=1", in_ready); end
        tick();
        offer(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 64'hC, 64'h0, 64'h0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_full got=%b exp=0", in_ready); end
        checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b0, 5'd1, 64'hA}) begin errors++; $display("FAIL stall_hold got=%b/%0d/%h exp=0/1/a", RegWrite, WriteRegister, WriteData); end
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_still_full got=%b exp=0", in_ready); end
        wr_grant = 1'b1; #1;
        checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd1, 64'hA}) begin errors++; $display("FAIL skid_write_a got=%b/%0d/%h exp=1/1/a", RegWrite, WriteRegister, WriteData); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back got=%b exp=1", in_ready); end
        checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd2, 64'hB}) begin errors++; $display("FAIL skid_write_b got=%b/%0d/%h exp=1/2/b", RegWrite, WriteRegister, WriteData); end
        tick();
        offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        checks++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd3, 64'hC}) begin errors++; $display("FAIL skid_write_c got=%b/%0d/%h exp=1/3/c", RegWrite, WriteRegister, WriteData); end
        tick();
        checks++; if (commit_count !== 4'd3) begin errors++; $display("FAIL skid_count got=%0d exp=3", commit_count); end
    endtask

    task automatic test_forwarding();
        do_reset();
        wr_grant = 1'b0;
        offer(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 64'hAA, 64'h0, 64'h0);
        tick();
        offer(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 64'hBB, 64'h0, 64'h0);
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd31; #1;
        checks++; if ({fwd_hit1, fwd_data1} !== {1'b1, 64'hAA}) begin errors++; $display("FAIL fwd_s_only got=%b/%h exp=1/aa", fwd_hit1, fwd_data1); end
        tick();
        offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        checks++; if ({fwd_hit1, fwd_data1} !== {1'b1, 64'hBB}) begin errors++; $display("FAIL fwd_b_wins got=%b/%h exp=1/bb", fwd_hit1, fwd_data1); end
        checks++; if ({fwd_hit2, fwd_data2} !== {1'b0, 64'h0}) begin errors++; $display("FAIL fwd_xzr got=%b/%h exp=0/0", fwd_hit2, fwd_data2); end
        ReadRegister2 = 5'd4; #1;
        checks++; if ({fwd_hit2, fwd_data2} !== {1'b0, 64'h0}) begin errors++; $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit2, fwd_data2); end
    endtask

    task automatic test_reset_mid_stall();
        test_forwarding();
        reset = 1'b1; wr_grant = 1'b0; #1;
        tick();
        reset = 1'b0; #1;
        checks++; if ({RegWrite, WriteRegister} !== {1'b0, 5'd31}) begin errors++; $display("FAIL rst_mid_port got=%b/%0d exp=0/31", RegWrite, WriteRegister); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        checks++; if (commit_count !== 4'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", commit_count); end
        wr_grant = 1'b1; #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_mid_discard got=%b exp=0", RegWrite); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        wr_grant = 1'b1;
        for (int i = 0; i < 17; i++) begin
            offer(1'b1, 5'(i % 30), 1'b1, 1'b0, 1'b0, 64'(i), 64'h0, 64'h0);
            tick();
        end
        offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        tick();
        checks++; if (commit_count !== 4'd1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", commit_count); end
    endtask

    task automatic test_random();
        logic [DW:0] f1, f2;
        logic [4:0] r;
        logic acc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!in_valid) begin
                r = 5'($urandom_range(0, 8));
                offer($urandom_range(0, 9) < 7, (r == 5'd8) ? 5'd31 : r, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 7) == 0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            end
            wr_grant = $urandom_range(0, 9) < 6;
            r = 5'($urandom_range(0, 9));
            ReadRegister1 = (r > 5'd8) ? 5'd31 : r;
            ReadRegister2 = 5'($urandom_range(0, 8));
            #1;
            f1 = exp_fwd(ReadRegister1);
            f2 = exp_fwd(ReadRegister2);
            checks++; if (RegWrite !== exp_regwrite()) begin errors++; $display("FAIL rnd_regwrite cyc=%0d got=%b exp=%b", i, RegWrite, exp_regwrite()); end
            checks++; if (WriteRegister !== exp_wreg()) begin errors++; $display("FAIL rnd_wreg cyc=%0d got=%0d exp=%0d", i, WriteRegister, exp_wreg()); end
            checks++; if (WriteData !== exp_wdata()) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", i, WriteData, exp_wdata()); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
            checks++; if ({fwd_hit1, fwd_data1} !== f1) begin errors++; $display("FAIL rnd_fwd1 cyc=%0d got=%b/%h exp=%b/%h", i, fwd_hit1, fwd_data1, f1[DW], f1[DW-1:0]); end
            checks++; if ({fwd_hit2, fwd_data2} !== f2) begin errors++; $display("FAIL rnd_fwd2 cyc=%0d got=%b/%h exp=%b/%h", i, fwd_hit2, fwd_data2, f2[DW], f2[DW-1:0]); end
            checks++; if (commit_count !== 4'(mcount)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, commit_count, mcount); end
            acc = in_valid && (q.size() < 2);
            tick();
            if (acc) in_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; wr_grant = 1'b0; in_valid = 1'b0; mcount = 0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        test_reset();
        test_back_to_back();
        test_xzr_link();
        test_stall_skid();
        test_forwarding();
        test_reset_mid_stall();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage that drives the register file's single write port (WriteData/WriteRegister/RegWrite) from results handed over by the MEM stage. It holds a one-entry stage register plus a one-entry skid buffer behind a valid/ready handshake. It stalls when the write port is not granted and supplies bypass data for both read ports, because regfile writes land only at the clock edge. X31 (XZR) is never written, and BL link writes are redirected to X30.

## Interface

Parameters:
- DW, 64, data width of result/write data.
- CW, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; one clock; sampled on posedge clk.
- in_valid  input  1  MEM stage offers a result this cycle.
- in_ready  output  1  unit accepts the offer this cycle (= skid buffer empty).
- in_rd  input  5  destination register.
- in_regwrite  input  1  instruction writes a register.
- in_memtoreg  input  1  select in_mem_data instead of in_alu_result.
- in_link  input  1  BL: write in_pc_plus4 to X30, overriding in_rd and in_memtoreg.
- in_alu_result, in_mem_data, in_pc_plus4  input  DW each  candidate write values.
- wr_grant  input  1  write port available this cycle (low while the debug writer owns the port).
- WriteData  output  DW  to regfile WriteData.
- WriteRegister  output  5  to regfile WriteRegister.
- RegWrite  output  1  to regfile RegWrite.
- ReadRegister1, ReadRegister2  input  5 each  the same indices presented to the regfile read ports.
- fwd_hit1, fwd_hit2  output  1 each  a pending write targets that read index.
- fwd_data1, fwd_data2  output  DW each  the pending value; zero when no hit.
- commit_count  output  CW  number of writes actually performed, wrapping.

## Operation

- Entry fields: valid, rd, we, data.
- Capture mapping on acceptance:
  - rd = in_link ? 30 : in_rd.
  - data = in_link ? in_pc_plus4 : (in_memtoreg ? in_mem_data : in_alu_result).
  - we = (in_link | in_regwrite) & (rd != 31).
- Acceptance: accept = in_valid & in_ready, where in_ready = ~B.valid. S is the stage register and B the skid buffer.
- Retire: retire = S.valid & wr_grant. An entry with we=0 still retires; it takes one granted cycle and causes no write.
- Write port is combinational from S:
  - RegWrite = S.valid & S.we & wr_grant.
  - WriteRegister = S.valid ? S.rd : 31.
  - WriteData = S.valid ? S.data : 0.
- Next state when S is free (S empty, or retire):
  - If B.valid: S <= B, B <= empty.
  - Else if accept: S <= captured entry.
  - Otherwise S <= empty.
- Next state when S is held (valid and wr_grant low): if accept, B <= captured entry. S is unchanged.
- Ordering: results retire strictly in acceptance order. No entry is dropped or duplicated.
- Forwarding for port n:
  - hitB = B.valid & B.we & (B.rd == ReadRegister_n).
  - hitS = S.valid & S.we & (S.rd == ReadRegister_n).
  - fwd_hit_n = hitB | hitS.
  - fwd_data_n = hitB ? B.data : (hitS ? S.data : 0). B is the younger entry and wins.
  - ReadRegister_n == 31 never hits.
- commit_count increments by 1 on every cycle with RegWrite=1 and wraps from 2^CW-1 to 0.

## Timing

- Reset (synchronous): S and B cleared to invalid and commit_count to 0.
  - Outputs in the cycle after the reset edge: RegWrite=0, WriteRegister=31, WriteData=0, in_ready=1, fwd_hit1/2=0, fwd_data1/2=0, commit_count=0.
  - Reset asserted mid-operation discards both entries and performs no write on that edge.
- Latency: an accepted result drives RegWrite in the next cycle if wr_grant is high. The regfile updates at the following edge (accept edge + 1).
- Throughput: with wr_grant held high, one result per cycle and in_ready stays 1.
- Stall with wr_grant low:
  - S is held.
  - One more result can be accepted into B, after which in_ready drops to 0.
  - in_ready returns to 1 one cycle after the first granted retire: B moves to S and B empties.
- in_ready is a registered value that depends only on state, with no combinational path from in_valid or wr_grant. MEM must hold its offer while in_ready=0.
- Simultaneous retire and accept with B empty: S is replaced by the new entry in the same edge, with no bubble.
- Forwarding outputs are combinational from state and ReadRegister1/2. The regfile read mux consumes them in the same cycle.

## Test plan

- Back-to-back: accept {rd=5, alu=64'h11}, then {rd=6, memtoreg=1, mem=64'h22}, wr_grant=1 -> RegWrite pulses in consecutive cycles with (5, 64'h11) then (6, 64'h22); commit_count=2; in_ready stays 1.
- XZR/link: {rd=31, regwrite=1} -> RegWrite never asserts, commit_count unchanged. {link=1, rd=7, pc_plus4=64'h1004} -> write (30, 64'h1004).
- Stall/skid: wr_grant=0, accept A(rd=1, 0xA) and B(rd=2, 0xB) -> in_ready=0 and the third offer is held. Raise wr_grant -> A writes, then B; in_ready=1 one cycle after A's write.
- Forwarding: S={rd=3, 0xAA}, B={rd=3, 0xBB} with ReadRegister1=3 -> fwd_hit1=1, fwd_data1=0xBB. ReadRegister2=31 -> fwd_hit2=0, fwd_data2=0.
- Reset mid-stall: both entries valid, assert reset one cycle -> no write, RegWrite=0, WriteRegister=31, in_ready=1, commit_count=0.
- Counter wrap (CW=4): 17 committed writes -> commit_count reads 1.
